data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Responder end of the load/store-buffer data access interface. Accepts a single
//   load or store request (byte/half/word), serialises it into byte-wide RAM
//   accesses via the shared memory arbiter, and answers with dataValid+dataOut
//   (load) or dataWriteSuc (store). Sits between the load/store buffer and the arbiter.
// PARAMETERS
//   IO_ADDR_HI  2'b11  value of addr[17:16] marking the memory-mapped I/O region
// PORTS
//   clockIn       in   1   clock; single clock domain
//   resetIn       in   1   reset; synchronous, active-high
//   clearIn       in   1   pipeline flush (acted on only when readyIn=1)
//   readyIn       in   1   global enable; 0 freezes all state
//   accessType    in   2   00 none, 01 byte, 10 half, 11 word; one-cycle request pulse
//   readWriteIn   in   1   1 read, 0 write
//   dataAddrIn    in   32  byte address of access
//   dataWriteIn   in   32  store data; low bytes used per size
//   dataValid     out  1   one-cycle pulse: dataOut holds load result
//   dataOut       out  32  load result, zero-extended (requester sign-extends)
//   dataWriteSuc  out  1   one-cycle pulse: store complete
//   memRequest    out  1   request ownership of RAM port
//   memGrant      in   1   arbiter grant; held while memRequest=1
//   memAddr       out  32  RAM byte address
//   memWrite      out  1   1 write byte this cycle
//   memOut        out  8   RAM write data
//   memIn         in   8   RAM read data, valid the cycle after address presented
//   ioBufferFull  in   1   I/O write buffer full; I/O stores must stall
// BEHAVIOUR
//   Reset: state IDLE; dataValid=0, dataWriteSuc=0, dataOut=0, memRequest=0,
//     memWrite=0, memAddr=0, memOut=0; byte counter 0.
//   FSM: IDLE -> WAIT_GRANT -> (READ | WRITE) -> RESPOND -> IDLE.
//   IDLE: if accessType!=0 and clearIn=0, latch addr/data/size/dir, set memRequest,
//     go WAIT_GRANT. Requests in any other state or with clearIn=1 are ignored.
//   WAIT_GRANT: stay until memGrant=1, then enter READ or WRITE with counter 0.
//   Size N = 1/2/4 bytes; byte i at addr+i, little-endian, no alignment check.
//   READ: cycles 0..N-1 present memAddr=addr+i, memWrite=0; cycle i+1 captures memIn
//     into dataOut[8i+7:8i]; after capturing byte N-1 go RESPOND; upper bytes = 0.
//   WRITE: cycle i drives memAddr=addr+i, memOut=byte i, memWrite=1. If
//     addr[17:16]==IO_ADDR_HI and ioBufferFull=1, memWrite=0 and counter holds.
//     After byte N-1 written go RESPOND.
//   RESPOND: memRequest=0; pulse dataValid (read) or dataWriteSuc (write) for
//     exactly one cycle; return to IDLE. Back-to-back: next request accepted the
//     cycle after RESPOND.
//   Latency (grant immediate, no stall): word read request cycle 0 -> dataValid
//     cycle 6; byte write request cycle 0 -> dataWriteSuc cycle 3.
//   readyIn=0: state, counter, outputs held, except memWrite forced 0; pulses extend.
//   clearIn=1 with readyIn=1: in-flight read aborts -> IDLE, memRequest=0, no dataValid;
//     in-flight write runs to completion and still pulses dataWriteSuc.
//   resetIn mid-transaction: immediate return to reset values; partial store not undone.
//   memWrite never 1 outside WRITE; memRequest never 1 in IDLE/RESPOND.
// TESTING
//   Word read addr 0x100, RAM 11,22,33,44, grant held -> dataValid cycle 6, dataOut=0x44332211.
//   Half write 0x0000BEEF at 0x202 -> mem[0x202]=EF, mem[0x203]=BE, dataWriteSuc cycle 4.
//   Byte write 0x41 to 0x30000, ioBufferFull high 3 cycles -> memWrite delayed 3 cycles, then one write.
//   Word read, clearIn after 2 bytes -> no dataValid, memRequest drops, next request served.
//   memGrant low 5 cycles, readyIn low 2 cycles mid-read -> result correct, latency +7.
//   Byte read 0x80 -> dataOut=0x00000080 (zero-extended); reset mid-write -> all outputs 0.

Source files
------------

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder_if
// Description : Request/response and byte-wide RAM port bundle for the data
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_responder_if;
    logic        clearIn;
    logic        readyIn;
    logic [1:0]  accessType;
    logic        readWriteIn;
    logic [31:0] dataAddrIn;
    logic [31:0] dataWriteIn;
    logic        dataValid;
    logic [31:0] dataOut;
    logic        dataWriteSuc;
    logic        memRequest;
    logic        memGrant;
    logic [31:0] memAddr;
    logic        memWrite;
    logic [7:0]  memOut;
    logic [7:0]  memIn;
    logic        ioBufferFull;

    modport slave (
        input  clearIn, readyIn, accessType, readWriteIn, dataAddrIn, dataWriteIn,
        input  memGrant, memIn, ioBufferFull,
        output dataValid, dataOut, dataWriteSuc, memRequest, memAddr, memWrite, memOut
    );

    modport master (
        output clearIn, readyIn, accessType, readWriteIn, dataAddrIn, dataWriteIn,
        output memGrant, memIn, ioBufferFull,
        input  dataValid, dataOut, dataWriteSuc, memRequest, memAddr, memWrite, memOut
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder
// Description : Serialises one byte/half/word load or store into byte-wide RAM
//               accesses through the shared arbiter and reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  wire                       clockIn,
    input  wire                       resetIn,
    data_memory_responder_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_GRANT = 3'd1,
        READ       = 3'd2,
        WRITE      = 3'd3,
        RESPOND    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_addr;
    logic [31:0] r_writeData;
    logic [31:0] r_dataOut;
    logic [1:0]  r_lastIdx;
    logic [1:0]  r_count;
    logic        r_isRead;

    logic        w_accept;
    logic        w_ioStall;
    logic [1:0]  w_fetchIdx;
    logic        w_memRequest;
    logic [31:0] w_memAddr;
    logic        w_memWrite;
    logic [7:0]  w_memOut;
    logic        w_dataValid;
    logic        w_dataWriteSuc;

    assign w_ioStall  = (r_addr[17:16] == IO_ADDR_HI) && bus.ioBufferFull;
    // Byte 0 is addressed during the grant cycle, so each READ cycle captures
    // one byte while issuing the address of the next.
    assign w_fetchIdx = (r_count == r_lastIdx) ? r_count : r_count + 2'd1;

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.accessType != 2'b00 && !bus.clearIn) begin
                    w_accept    = 1'b1;
                    w_nextState = WAIT_GRANT;
                end
            end
            WAIT_GRANT: begin
                if (bus.clearIn && r_isRead)
                    w_nextState = IDLE;
                else if (bus.memGrant)
                    w_nextState = r_isRead ? READ : WRITE;
            end
            READ: begin
                if (bus.clearIn)
                    w_nextState = IDLE;
                else if (r_count == r_lastIdx)
                    w_nextState = RESPOND;
            end
            WRITE: begin
                if (!w_ioStall && r_count == r_lastIdx)
                    w_nextState = RESPOND;
            end
            RESPOND:  w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            r_state     <= IDLE;
            r_addr      <= 32'd0;
            r_writeData <= 32'd0;
            r_dataOut   <= 32'd0;
            r_lastIdx   <= 2'd0;
            r_count     <= 2'd0;
            r_isRead    <= 1'b0;
        end else if (bus.readyIn) begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= bus.dataAddrIn;
                        r_writeData <= bus.dataWriteIn;
                        r_isRead    <= bus.readWriteIn;
                        r_count     <= 2'd0;
                        r_lastIdx   <= (bus.accessType == 2'b11) ? 2'd3 :
                                       (bus.accessType == 2'b10) ? 2'd1 : 2'd0;
                        if (bus.readWriteIn)
                            r_dataOut <= 32'd0;
                    end
                end
                WAIT_GRANT: r_count <= 2'd0;
                READ: begin
                    r_dataOut[{r_count, 3'b000} +: 8] <= bus.memIn;
                    r_count <= r_count + 2'd1;
                end
                WRITE: begin
                    if (!w_ioStall)
                        r_count <= r_count + 2'd1;
                end
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_memRequest   = 1'b0;
        w_memAddr      = 32'd0;
        w_memWrite     = 1'b0;
        w_memOut       = 8'd0;
        w_dataValid    = 1'b0;
        w_dataWriteSuc = 1'b0;
        case (r_state)
            WAIT_GRANT: begin
                w_memRequest = 1'b1;
                w_memAddr    = r_addr;
            end
            READ: begin
                w_memRequest = 1'b1;
                w_memAddr    = r_addr + {30'd0, w_fetchIdx};
            end
            WRITE: begin
                w_memRequest = 1'b1;
                w_memAddr    = r_addr + {30'd0, r_count};
                w_memOut     = r_writeData[{r_count, 3'b000} +: 8];
                w_memWrite   = bus.readyIn && !w_ioStall;
            end
            RESPOND: begin
                w_dataValid    = r_isRead;
                w_dataWriteSuc = !r_isRead;
            end
            default: w_memRequest = 1'b0;
        endcase
    end

    assign bus.memRequest   = w_memRequest;
    assign bus.memAddr      = w_memAddr;
    assign bus.memWrite     = w_memWrite;
    assign bus.memOut       = w_memOut;
    assign bus.dataValid    = w_dataValid;
    assign bus.dataWriteSuc = w_dataWriteSuc;
    assign bus.dataOut      = r_dataOut;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_responder
// Description : Scoreboard bench for data_memory_responder with a byte RAM and
//               arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    typedef struct {
        logic        isRead;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clockIn;
    logic resetIn;
    logic grantEn;
    logic preWe;
    logic [17:0] preAddr;
    logic [7:0]  preData;
    logic [7:0]  mem [0:262143];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   writeCount = 0;
    int   lastWriteCycle = -1;
    int   k;
    int   wrBefore;
    exp_t expQ[$];

    data_memory_responder_if bus();

    data_memory_responder #(.IO_ADDR_HI(2'b11)) dut (
        .clockIn (clockIn),
        .resetIn (resetIn),
        .bus     (bus)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    always @(posedge clockIn) cyc <= cyc + 1;

    assign bus.memGrant = bus.memRequest & grantEn;

    // Byte RAM: one-cycle read latency, frozen along with the rest of the system when readyIn=0.
    always @(posedge clockIn) begin
        if (preWe)
            mem[preAddr] <= preData;
        else if (bus.readyIn) begin
            bus.memIn <= mem[bus.memAddr[17:0]];
            if (bus.memWrite)
                mem[bus.memAddr[17:0]] <= bus.memOut;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clockIn);
        #1;
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        preAddr = a;
        preData = d;
        preWe   = 1'b1;
        tick(1);
        preWe   = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sz, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input bit expectResp,
                         input logic [31:0] expData, input int lat);
        bus.accessType  = sz;
        bus.readWriteIn = rd;
        bus.dataAddrIn  = a;
        bus.dataWriteIn = d;
        if (expectResp)
            expQ.push_back('{rd, expData, cyc + lat});
        tick(1);
        bus.accessType = 2'b00;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clockIn);
            if (!resetIn && bus.readyIn) begin
                if (bus.memWrite) begin
                    writeCount++;
                    lastWriteCycle = cyc;
                end
                if (bus.dataValid || bus.dataWriteSuc) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: got dataValid=%b dataWriteSuc=%b, expected none (cycle %0d)",
                                 bus.dataValid, bus.dataWriteSuc, cyc);
                    end else begin
                        e = expQ.pop_front();
                        chk("resp_kind", {31'd0, bus.dataValid}, {31'd0, e.isRead});
                        if (e.isRead)
                            chk("load_data", bus.dataOut, e.data);
                        chk("resp_cycle", cyc, e.due);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #50000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1);
            end
        join_none

        resetIn          = 1'b1;
        grantEn          = 1'b1;
        preWe            = 1'b0;
        preAddr          = 18'd0;
        preData          = 8'd0;
        bus.clearIn      = 1'b0;
        bus.readyIn      = 1'b1;
        bus.accessType   = 2'b00;
        bus.readWriteIn  = 1'b0;
        bus.dataAddrIn   = 32'd0;
        bus.dataWriteIn  = 32'd0;
        bus.ioBufferFull = 1'b0;
        tick(2);

        poke(18'h100, 8'h11); poke(18'h101, 8'h22); poke(18'h102, 8'h33); poke(18'h103, 8'h44);
        poke(18'h400, 8'h01); poke(18'h401, 8'h02); poke(18'h402, 8'h03); poke(18'h403, 8'h04);
        poke(18'h500, 8'hA1); poke(18'h501, 8'hB2); poke(18'h502, 8'hC3); poke(18'h503, 8'hD4);
        poke(18'h600, 8'h80); poke(18'h900, 8'h00);
        poke(18'h800, 8'h00); poke(18'h801, 8'h00); poke(18'h802, 8'h00); poke(18'h803, 8'h00);

        resetIn = 1'b0;
        tick(1);
        chk("reset_dataValid",    {31'd0, bus.dataValid},    32'd0);
        chk("reset_dataWriteSuc", {31'd0, bus.dataWriteSuc}, 32'd0);
        chk("reset_dataOut",      bus.dataOut,               32'd0);
        chk("reset_memRequest",   {31'd0, bus.memRequest},   32'd0);
        chk("reset_memWrite",     {31'd0, bus.memWrite},     32'd0);
        chk("reset_memAddr",      bus.memAddr,               32'd0);
        chk("reset_memOut",       {24'd0, bus.memOut},       32'd0);

        // Word read, immediate grant
        issue(2'b11, 1'b1, 32'h100, 32'd0, 1'b1, 32'h44332211, 6);
        tick(6);

        // Half write
        issue(2'b10, 1'b0, 32'h202, 32'h0000BEEF, 1'b1, 32'd0, 4);
        tick(4);
        chk("half_write_lo", {24'd0, mem[18'h202]}, 32'h000000EF);
        chk("half_write_hi", {24'd0, mem[18'h203]}, 32'h000000BE);

        // I/O byte write with a full buffer for 3 cycles
        bus.ioBufferFull = 1'b1;
        k = cyc;
        wrBefore = writeCount;
        issue(2'b01, 1'b0, 32'h30000, 32'h00000041, 1'b1, 32'd0, 6);
        tick(4);
        bus.ioBufferFull = 1'b0;
        tick(2);
        chk("io_write_count", writeCount - wrBefore, 32'd1);
        chk("io_write_cycle", lastWriteCycle, k + 5);
        chk("io_write_data",  {24'd0, mem[18'h30000]}, 32'h00000041);

        // Word read aborted by clear after two bytes, then a byte read
        k = cyc;
        issue(2'b11, 1'b1, 32'h400, 32'd0, 1'b0, 32'd0, 0);
        tick(3);
        bus.clearIn = 1'b1;
        tick(1);
        bus.clearIn = 1'b0;
        chk("abort_memRequest", {31'd0, bus.memRequest}, 32'd0);
        issue(2'b01, 1'b1, 32'h600, 32'd0, 1'b1, 32'h00000080, 3);
        tick(3);

        // Clear during a store does not cancel it
        issue(2'b01, 1'b0, 32'h700, 32'h0000005A, 1'b1, 32'd0, 3);
        bus.clearIn = 1'b1;
        tick(1);
        bus.clearIn = 1'b0;
        tick(2);
        chk("clear_write_data", {24'd0, mem[18'h700]}, 32'h0000005A);

        // Request while busy is ignored; back-to-back request after RESPOND
        issue(2'b01, 1'b1, 32'h600, 32'd0, 1'b1, 32'h00000080, 3);
        issue(2'b11, 1'b0, 32'h900, 32'hFFFFFFFF, 1'b0, 32'd0, 0);
        tick(2);
        issue(2'b01, 1'b0, 32'h701, 32'h00000066, 1'b1, 32'd0, 3);
        tick(3);
        chk("b2b_write_data",  {24'd0, mem[18'h701]}, 32'h00000066);
        chk("busy_req_ignored", {24'd0, mem[18'h900]}, 32'h00000000);

        // Grant withheld 5 cycles, readyIn low 2 cycles mid-read
        grantEn = 1'b0;
        issue(2'b11, 1'b1, 32'h500, 32'd0, 1'b1, 32'hD4C3B2A1, 13);
        tick(5);
        grantEn = 1'b1;
        tick(2);
        bus.readyIn = 1'b0;
        tick(2);
        bus.readyIn = 1'b1;
        tick(4);

        // Reset in the middle of a word store
        issue(2'b11, 1'b0, 32'h800, 32'hCAFEF00D, 1'b0, 32'd0, 0);
        tick(2);
        resetIn = 1'b1;
        tick(1);
        chk("rst_mid_dataValid",    {31'd0, bus.dataValid},    32'd0);
        chk("rst_mid_dataWriteSuc", {31'd0, bus.dataWriteSuc}, 32'd0);
        chk("rst_mid_memRequest",   {31'd0, bus.memRequest},   32'd0);
        chk("rst_mid_memWrite",     {31'd0, bus.memWrite},     32'd0);
        chk("rst_mid_memAddr",      bus.memAddr,               32'd0);
        chk("rst_mid_memOut",       {24'd0, bus.memOut},       32'd0);
        chk("rst_mid_dataOut",      bus.dataOut,               32'd0);
        chk("rst_partial_b0", {24'd0, mem[18'h800]}, 32'h0000000D);
        chk("rst_partial_b1", {24'd0, mem[18'h801]}, 32'h000000F0);
        chk("rst_partial_b2", {24'd0, mem[18'h802]}, 32'h00000000);
        resetIn = 1'b0;
        tick(2);

        for (int i = 0; i < 50 && expQ.size() != 0; i++)
            tick(1);
        chk("scoreboard_drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
